// File: rtl/usb_fifo_byte_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_fifo_byte_serializer_pkg
//  Purpose  : Shared constants, state encodings, word type and byte-select
//             helper for the 64-bit word to USB FIFO byte serializer.
//  Revision : 1.0  initial release
// ============================================================================
package usb_fifo_byte_serializer_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    // Serializer FSM encodings (2-bit)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_SIWU = 2'd2;

    // Packet word together with its end-of-event flag
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } word_t;

    // Byte number idx of a word in transmit order; msb_first puts [63:56] first
    function automatic logic [7:0] sel_byte(input logic [63:0]      word,
                                            input logic [IDX_W-1:0] idx,
                                            input logic             msb_first);
        logic [IDX_W-1:0] lane;
        lane = msb_first ? (LAST_IDX - idx) : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_fifo_byte_serializer_hold.sv
`default_nettype none
// ============================================================================
//  Module   : word_hold_reg
//  Purpose  : One-entry holding register with last flag. in_ready is a
//             registered copy of "empty". When empty, an arriving word is
//             passed straight through so an idle consumer can take it on the
//             same edge it is transferred.
//  Revision : 1.0  initial release
// ============================================================================
module word_hold_reg
    import usb_fifo_byte_serializer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,          // asynchronous, active low
    input  word_t in_word,
    input  logic  in_valid,
    output logic  in_ready,
    input  logic  take,         // consumer takes out_word this edge
    output word_t out_word,
    output logic  out_valid,
    output logic  held          // a word is stored in the register
);

    logic  valid_q;
    logic  valid_d;
    logic  ready_q;
    word_t word_q;
    logic  xfer;

    assign xfer      = in_valid && ready_q;
    assign out_valid = valid_q || xfer;
    assign out_word  = valid_q ? word_q : in_word;
    assign in_ready  = ready_q;
    assign held      = valid_q;

    // A stored word can only leave; an empty register fills unless bypassed
    always_comb begin
        valid_d = valid_q ? !take : (xfer && !take);
    end

    // Storage, occupancy and the registered ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= !valid_d;
            if (xfer) begin
                word_q <= in_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : usb_fifo_byte_serializer
//  Purpose  : Writes 64-bit packet words byte by byte into an FT245-style
//             synchronous USB FIFO, with one word double-buffered behind the
//             shifter and an optional send-immediate pulse after each event.
//  Revision : 1.0  initial release
// ============================================================================
module usb_fifo_byte_serializer
    import usb_fifo_byte_serializer_pkg::*;
#(
    parameter bit SIWU_EN     = 1'b1,
    parameter int SIWU_CYCLES = 2,       // 1..15
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,             // asynchronous, active low
    input  logic [63:0] word_data,
    input  logic        word_last,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        word_sent,
    input  logic        usb_txe_n,
    output logic [7:0]  usb_data,
    output logic        usb_wr_n,
    output logic        usb_siwu_n,
    output logic [15:0] event_count,
    output logic        busy
);

    localparam logic [3:0] SIWU_LOAD = 4'(SIWU_CYCLES - 1);

    logic [1:0]       state_q,       state_d;
    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [63:0]      shift_q,       shift_d;
    logic             shift_last_q,  shift_last_d;
    logic [3:0]       siwu_cnt_q,    siwu_cnt_d;
    logic             sent_q,        sent_d;
    logic [15:0]      event_count_q, event_count_d;

    word_t hold_in;
    word_t hold_out;
    logic  hold_out_valid;
    logic  hold_held;
    logic  take;
    logic  load;
    logic  accept;

    assign hold_in = '{data: word_data, last: word_last};

    word_hold_reg u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_word   (hold_in),
        .in_valid  (word_valid),
        .in_ready  (word_ready),
        .take      (take),
        .out_word  (hold_out),
        .out_valid (hold_out_valid),
        .held      (hold_held)
    );

    // The FIFO takes a byte only on an edge where our strobe and its space flag are both low
    assign accept = (state_q == ST_SEND) && !usb_txe_n;

    // Next-state: byte stepping, end-of-word routing, SIWU timing, event counting
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        shift_last_d  = shift_last_q;
        siwu_cnt_d    = siwu_cnt_q;
        sent_d        = 1'b0;
        event_count_d = event_count_q;
        load          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load = hold_out_valid;
            end
            ST_SEND: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sent_d = 1'b1;
                        if (shift_last_q) begin
                            event_count_d = event_count_q + 16'd1;
                        end
                        if (shift_last_q && SIWU_EN) begin
                            state_d    = ST_SIWU;
                            siwu_cnt_d = SIWU_LOAD;
                        end else if (hold_out_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_SIWU: begin
                if (siwu_cnt_q == 4'd0) begin
                    if (hold_out_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    siwu_cnt_d = siwu_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Shared reload path: IDLE start, back-to-back word and post-SIWU restart
        take = load;
        if (load) begin
            shift_d      = hold_out.data;
            shift_last_d = hold_out.last;
            idx_d        = '0;
            state_d      = ST_SEND;
        end
    end

    // State registers; reset abandons any partial and held word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            shift_last_q  <= 1'b0;
            siwu_cnt_q    <= '0;
            sent_q        <= 1'b0;
            event_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            shift_last_q  <= shift_last_d;
            siwu_cnt_q    <= siwu_cnt_d;
            sent_q        <= sent_d;
            event_count_q <= event_count_d;
        end
    end

    // Strobes decode straight from state so reset releases them immediately
    assign usb_wr_n    = (state_q != ST_SEND);
    assign usb_siwu_n  = (state_q != ST_SIWU);
    assign usb_data    = (state_q == ST_SEND) ? sel_byte(shift_q, idx_q, MSB_FIRST) : 8'h00;
    assign word_sent   = sent_q;
    assign event_count = event_count_q;
    assign busy        = (state_q != ST_IDLE) || hold_held;

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_fifo_byte_serializer
//  Purpose  : Self-checking bench for usb_fifo_byte_serializer. Issued words
//             push their bytes into an expected queue; a monitor pops and
//             compares on every accepted FIFO write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_fifo_byte_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] word_data = '0;
    logic        word_last = 1'b0;
    logic        word_valid = 1'b0;
    logic        usb_txe_n = 1'b0;
    logic        word_ready;
    logic        word_sent;
    logic [7:0]  usb_data;
    logic        usb_wr_n;
    logic        usb_siwu_n;
    logic [15:0] event_count;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_total = 0;
    int sent_total = 0;
    int sent_cyc = -1;
    int siwu_total = 0;
    int siwu_start = -1;
    logic prev_siwu_n = 1'b1;

    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         acc_cyc_q[$];

    usb_fifo_byte_serializer #(
        .SIWU_EN     (1'b1),
        .SIWU_CYCLES (2),
        .MSB_FIRST   (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .word_data   (word_data),
        .word_last   (word_last),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_sent   (word_sent),
        .usb_txe_n   (usb_txe_n),
        .usb_data    (usb_data),
        .usb_wr_n    (usb_wr_n),
        .usb_siwu_n  (usb_siwu_n),
        .event_count (event_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges so far
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: a write seen at the falling edge is taken by the FIFO at the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            if (!usb_wr_n && !usb_txe_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, required no write", usb_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (usb_data !== e) begin
                        errors++;
                        $display("FAIL byte_order: got %h, required %h", usb_data, e);
                    end
                end
                acc_total++;
                log_q.push_back(usb_data);
                acc_cyc_q.push_back(cyc);
            end
            if (!usb_siwu_n) begin
                siwu_total++;
                if (prev_siwu_n) siwu_start = cyc;
                if (!usb_wr_n) begin
                    checks++;
                    errors++;
                    $display("FAIL siwu_overlap: usb_wr_n got 0, required 1 during SIWU");
                end
            end
            if (word_sent) begin
                sent_total++;
                sent_cyc = cyc;
            end
            prev_siwu_n = usb_siwu_n;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the transfer edge (xcyc = that edge's number)
    task automatic send_word(input logic [63:0] d, input logic l, output int xcyc);
        word_data  = d;
        word_last  = l;
        word_valid = 1'b1;
        xcyc       = -1;
        for (int i = 0; i < 300; i++) begin
            if (word_ready) begin
                @(posedge clk);
                #1;
                xcyc = cyc;
                for (int b = 0; b < 8; b++) exp_q.push_back(d[63 - 8*b -: 8]);
                word_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        word_valid = 1'b0;
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (!busy && usb_siwu_n && exp_q.size() == 0) break;
        end
        if (n == 400) chk("idle_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int n;
        for (n = 0; n < 200; n++) begin
            if (acc_total == target) break;
            @(posedge clk);
            #1;
        end
        if (n == 200) chk("acc_timeout", 64'(acc_total), 64'(target));
    endtask

    initial begin
        logic [7:0] t1_exp [8];
        int x, x2, x3, base, s0, sw0;
        t1_exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

        // Reset state
        #3;
        chk("rst_word_ready", word_ready, 0);
        chk("rst_usb_wr_n",   usb_wr_n,   1);
        chk("rst_usb_siwu_n", usb_siwu_n, 1);
        chk("rst_usb_data",   usb_data,   0);
        chk("rst_event_count", event_count, 0);
        chk("rst_busy",       busy,       0);
        chk("rst_word_sent",  word_sent,  0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", word_ready, 1);

        // 1: single word, MSB first, latency
        log_q.delete();
        acc_cyc_q.delete();
        send_word(64'h0123456789ABCDEF, 1'b0, x);
        wait_idle();
        chk("t1_byte_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_byte", log_q[i], t1_exp[i]);
        chk("t1_first_strobe_cyc", acc_cyc_q[0], x);
        chk("t1_byte7_cyc", acc_cyc_q[7], x + 7);
        chk("t1_word_sent_cyc", sent_cyc, x + 8);

        // 2: three back-to-back words, no gap between strobes
        acc_cyc_q.delete();
        s0 = sent_total;
        send_word(64'h1111111111111111, 1'b0, x);
        send_word(64'h2222222222222222, 1'b0, x2);
        send_word(64'h3333333333333333, 1'b0, x3);
        wait_idle();
        chk("t2_byte_count", acc_cyc_q.size(), 24);
        chk("t2_span", 64'(acc_cyc_q[23] - acc_cyc_q[0]), 23);
        chk("t2_word_sent", 64'(sent_total - s0), 3);

        // 3: FIFO full for 5 cycles after byte 3; byte 4 (0x76) must be held
        base = acc_total;
        send_word(64'hFEDCBA9876543210, 1'b0, x);
        wait_acc(base + 4);
        usb_txe_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_byte4", {usb_wr_n, usb_data}, {1'b0, 8'h76});
            @(posedge clk);
            #1;
        end
        chk("t3_no_accept_while_full", 64'(acc_total), 64'(base + 4));
        usb_txe_n = 1'b0;
        wait_idle();
        chk("t3_total", 64'(acc_total), 64'(base + 8));

        // 3b: txe toggling every cycle
        base = acc_total;
        send_word(64'h1122334455667788, 1'b0, x);
        for (int i = 0; i < 40; i++) begin
            usb_txe_n = ~usb_txe_n;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        usb_txe_n = 1'b0;
        wait_idle();
        chk("t3b_total", 64'(acc_total), 64'(base + 8));

        // 4: last word -> 2-cycle SIWU after byte 7, next word follows
        acc_cyc_q.delete();
        sw0 = siwu_total;
        send_word(64'hA5A50000FFFF5A5A, 1'b1, x);
        send_word(64'h0F0F0F0FF0F0F0F0, 1'b0, x2);
        wait_idle();
        chk("t4_event_count", event_count, 1);
        chk("t4_siwu_len", 64'(siwu_total - sw0), 2);
        chk("t4_siwu_start", 64'(siwu_start), 64'(acc_cyc_q[7] + 1));
        chk("t4_next_word_start", 64'(acc_cyc_q[8]), 64'(acc_cyc_q[7] + 3));
        chk("t4_byte_count", acc_cyc_q.size(), 16);

        // 5: reset at byte 5 with a word held
        base = acc_total;
        send_word(64'hDEADBEEFCAFEF00D, 1'b0, x);
        send_word(64'h5555AAAA5555AAAA, 1'b0, x2);
        wait_acc(base + 5);
        chk("t5_byte5_on_bus", {usb_wr_n, usb_data}, {1'b0, 8'hFE});
        chk("t5_hold_full", word_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_wr_n_async", usb_wr_n, 1);
        chk("t5_busy_reset", busy, 0);
        chk("t5_count_reset", event_count, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("t5_no_stale_activity", {busy, usb_wr_n}, {1'b0, 1'b1});
        base = acc_total;
        send_word(64'h0102030405060708, 1'b0, x);
        wait_idle();
        chk("t5_fresh_word", 64'(acc_total), 64'(base + 8));
        chk("t5_event_count", event_count, 0);

        // 6: wrap 0xFFFF -> 0; counter preloaded by force instead of 65535 events
        force dut.event_count_q = 16'hFFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        release dut.event_count_q;
        @(posedge clk);
        #1;
        chk("t6_preload", event_count, 16'hFFFF);
        send_word(64'h8877665544332211, 1'b1, x);
        wait_idle();
        chk("t6_wrap", event_count, 16'h0000);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
